rs_key_eqn_solver: RTL and testbench

RS_KEY_EQN_SOLVER -- requirements
Module: rs_key_eqn_solver

---
 rtl/rs_key_eqn_solver.sv | 225 ++++++++++++++++++++++
 tb/tb_rs_key_eqn_solver.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_key_eqn_solver.sv
// rtl/rs_key_eqn_solver.sv - Inversionless Euclidean key-equation solver for Reed-Solomon over GF(256)
module rs_key_eqn_solver #(
    parameter int         NSYND   = 4,
    parameter logic [8:0] GF_POLY = 9'h11D
) (
    input  logic                        i_clk,
    input  logic                        i_res,
    input  logic                        i_start,
    input  logic [8*NSYND-1:0]          i_synd,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [8*(NSYND/2+1)-1:0]    o_lambda,
    output logic [8*(NSYND/2)-1:0]      o_omega,
    output logic [$clog2(NSYND/2+1):0]  o_nerr,
    output logic                        o_fail
);
    localparam int T  = NSYND / 2;
    localparam int DW = $clog2(NSYND + 2);
    localparam int NW = $clog2(T + 1) + 1;
    localparam logic [DW-1:0] T_D   = DW'(T);
    localparam logic [DW-1:0] ONE_D = DW'(1);

    typedef enum logic [1:0] { S_IDLE, S_ITER, S_FIN } state_t;
    typedef logic [NSYND:0][7:0] poly_t;
    typedef logic [T:0][7:0]     lam_t;
    typedef logic [T-1:0][7:0]   om_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ GF_POLY[7:0]) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic poly_t poly_scale(input poly_t p, input logic [7:0] c);
        poly_t res;
        for (int i = 0; i <= NSYND; i++) res[i] = gf_mul(p[i], c);
        return res;
    endfunction

    function automatic lam_t lam_scale(input lam_t p, input logic [7:0] c);
        lam_t res;
        for (int i = 0; i <= T; i++) res[i] = gf_mul(p[i], c);
        return res;
    endfunction

    state_t          state_q, state_d;
    poly_t           r_q, r_d, q_q, q_d;
    lam_t            lr_q, lr_d, lq_q, lq_d;
    logic [DW-1:0]   degr_q, degr_d, degq_q, degq_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    lam_t            lambda_q, lambda_d;
    om_t             omega_q, omega_d;
    logic [NW-1:0]   nerr_q, nerr_d;
    logic            fail_q, fail_d;

    logic            swap;
    poly_t           sr, sq, sq_sh, r_new;
    lam_t            slr, slq, slq_sh, lr_new;
    logic [DW-1:0]   sdr, sdq, shift_d;
    logic [7:0]      coef_a, coef_b;
    logic            lam_ovf;

    lam_t            fin_lam;
    om_t             fin_om;
    logic [NW-1:0]   fin_nerr, fin_degom;
    logic            fin_omnz, fin_fail;

    // Iteration datapath: order the pair so R has the higher degree, then cross-multiply
    always_comb begin
        swap    = (degr_q < degq_q);
        sr      = swap ? q_q : r_q;
        sq      = swap ? r_q : q_q;
        slr     = swap ? lq_q : lr_q;
        slq     = swap ? lr_q : lq_q;
        sdr     = swap ? degq_q : degr_q;
        sdq     = swap ? degr_q : degq_q;
        coef_a  = sr[sdr];
        coef_b  = sq[sdq];
        shift_d = sdr - sdq;
        sq_sh   = sq << {shift_d, 3'b000};
        slq_sh  = slq << {shift_d, 3'b000};
        r_new   = poly_scale(sr, coef_b) ^ poly_scale(sq_sh, coef_a);
        lr_new  = lam_scale(slr, coef_b) ^ lam_scale(slq_sh, coef_a);
        lam_ovf = 1'b0;
        for (int j = 0; j <= T; j++) begin
            if (slq[j] != 8'h00 && (j + int'(shift_d)) > T) lam_ovf = 1'b1;
        end
    end

    // Result selection: the pair whose degree dropped below T holds Omega and Lambda
    always_comb begin
        fin_lam   = (degr_q < T_D) ? lr_q : lq_q;
        fin_om    = (degr_q < T_D) ? r_q[T-1:0] : q_q[T-1:0];
        fin_nerr  = '0;
        for (int k = 0; k <= T; k++) begin
            if (fin_lam[k] != 8'h00) fin_nerr = NW'(k);
        end
        fin_omnz  = 1'b0;
        fin_degom = '0;
        for (int k = 0; k < T; k++) begin
            if (fin_om[k] != 8'h00) begin
                fin_omnz  = 1'b1;
                fin_degom = NW'(k);
            end
        end
        fin_fail = (fin_lam[0] == 8'h00) || (fin_omnz && (fin_degom >= fin_nerr)) || ovf_q;
    end

    // Next-state logic: load on start, one Euclid step per ITER cycle, publish in FIN
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        q_d      = q_q;
        lr_d     = lr_q;
        lq_d     = lq_q;
        degr_d   = degr_q;
        degq_d   = degq_q;
        ovf_d    = ovf_q;
        lambda_d = lambda_q;
        omega_d  = omega_q;
        nerr_d   = nerr_q;
        fail_d   = fail_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_ITER;
                    r_d       = '0;
                    r_d[NSYND] = 8'h01;
                    q_d       = '0;
                    for (int k = 0; k < NSYND; k++) q_d[k] = i_synd[8*k +: 8];
                    lr_d      = '0;
                    lq_d      = '0;
                    lq_d[0]   = 8'h01;
                    degr_d    = DW'(NSYND);
                    degq_d    = DW'(NSYND - 1);
                    ovf_d     = 1'b0;
                end
            end
            S_ITER: begin
                if (degr_q < T_D || degq_q < T_D) begin
                    state_d = S_FIN;
                end else begin
                    r_d    = sr;
                    q_d    = sq;
                    lr_d   = slr;
                    lq_d   = slq;
                    degr_d = sdr;
                    degq_d = sdq;
                    if (coef_a == 8'h00) begin
                        degr_d = sdr - ONE_D;
                    end else if (coef_b == 8'h00) begin
                        degq_d = sdq - ONE_D;
                    end else begin
                        r_d    = r_new;
                        lr_d   = lr_new;
                        degr_d = sdr - ONE_D;
                        ovf_d  = ovf_q | lam_ovf;
                    end
                end
            end
            S_FIN: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                lambda_d = fin_lam;
                omega_d  = fin_om;
                nerr_d   = fin_nerr;
                fail_d   = fin_fail;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any run and clears all results
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            q_q      <= '0;
            lr_q     <= '0;
            lq_q     <= '0;
            degr_q   <= '0;
            degq_q   <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lambda_q <= '0;
            omega_q  <= '0;
            nerr_q   <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            q_q      <= q_d;
            lr_q     <= lr_d;
            lq_q     <= lq_d;
            degr_q   <= degr_d;
            degq_q   <= degq_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lambda_q <= lambda_d;
            omega_q  <= omega_d;
            nerr_q   <= nerr_d;
            fail_q   <= fail_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_lambda = lambda_q;
    assign o_omega  = omega_q;
    assign o_nerr   = nerr_q;
    assign o_fail   = fail_q;

endmodule

// File: tb/tb_rs_key_eqn_solver.sv
// tb/tb_rs_key_eqn_solver.sv - Scoreboard bench for rs_key_eqn_solver against an error-pattern model
module tb_rs_key_eqn_solver;
    localparam int NSYND = 4;
    localparam int T     = NSYND / 2;
    localparam int NW    = $clog2(T + 1) + 1;
    localparam int MAXLAT = NSYND + 2;

    logic                   clk   = 1'b0;
    logic                   rst   = 1'b1;
    logic                   start = 1'b0;
    logic [8*NSYND-1:0]     synd  = '0;
    logic                   busy, done, fail;
    logic [8*(T+1)-1:0]     lam;
    logic [8*T-1:0]         om;
    logic [NW-1:0]          nerr;

    rs_key_eqn_solver #(.NSYND(NSYND), .GF_POLY(9'h11D)) dut (
        .i_clk    (clk),
        .i_res    (rst),
        .i_start  (start),
        .i_synd   (synd),
        .o_busy   (busy),
        .o_done   (done),
        .o_lambda (lam),
        .o_omega  (om),
        .o_nerr   (nerr),
        .o_fail   (fail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] gexp [0:254];
    int         glog [0:255];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        return gexp[(255 - glog[a]) % 255];
    endfunction

    // kind 0: exact values; kind 1: values up to a common nonzero scale; kind 2: completion only
    typedef struct {
        int                 kind;
        logic [8*(T+1)-1:0] lam;
        logic [8*T-1:0]     om;
        int                 nerr;
        bit                 fail;
        int                 c0;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic exp_t mk_exact(input logic [8*(T+1)-1:0] l, input logic [8*T-1:0] o, input int ne);
        exp_t e;
        e.kind = 0; e.lam = l; e.om = o; e.nerr = ne; e.fail = 1'b0; e.c0 = 0;
        return e;
    endfunction

    exp_t               mon_e;
    logic [7:0]         l0, sc;
    logic [8*(T+1)-1:0] nlam;
    logic [8*T-1:0]     nom;

    // Monitor: every o_done pulse retires exactly one scoreboard entry
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                n_checks++;
                if (cyc - mon_e.c0 <= MAXLAT) n_pass++;
                else $display("FAIL latency: got %0d cycles, required <= %0d", cyc - mon_e.c0, MAXLAT);
                if (mon_e.kind == 0) begin
                    chk("lambda", lam, mon_e.lam);
                    chk("omega", om, mon_e.om);
                    chk("nerr", nerr, mon_e.nerr);
                    chk("fail", fail, mon_e.fail);
                end else if (mon_e.kind == 1) begin
                    l0 = lam[7:0];
                    chk("lambda0_nonzero", l0 != 8'h00, 64'd1);
                    sc = (l0 != 8'h00) ? ginv(l0) : 8'h01;
                    for (int k = 0; k <= T; k++) nlam[8*k +: 8] = gmul(lam[8*k +: 8], sc);
                    for (int k = 0; k < T; k++) nom[8*k +: 8] = gmul(om[8*k +: 8], sc);
                    chk("lambda_scaled", nlam, mon_e.lam);
                    chk("omega_scaled", nom, mon_e.om);
                    chk("nerr_rand", nerr, mon_e.nerr);
                    chk("fail_rand", fail, mon_e.fail);
                end
            end
        end
    end

    task automatic issue(input logic [8*NSYND-1:0] s, input exp_t e);
        @(negedge clk);
        start = 1'b1;
        synd  = s;
        e.c0  = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (sbq.size() != 0 && g < 4*NSYND + 20) begin
            @(negedge clk);
            g++;
        end
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL done_timeout: %0d results outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Build syndromes from v random errors; Lambda = prod(1 + X_i x), Omega = Lambda*S mod x^T
    task automatic run_errors(input int v);
        int                 p [0:7];
        logic [7:0]         y [0:7];
        logic [7:0]         s [0:NSYND-1];
        logic [7:0]         lm [0:NSYND];
        logic [7:0]         acc;
        logic [8*NSYND-1:0] sv;
        exp_t               e;
        bit                 dup;
        for (int i = 0; i < v; i++) begin
            do begin
                p[i] = int'($urandom_range(254));
                dup  = 1'b0;
                for (int j = 0; j < i; j++) if (p[j] == p[i]) dup = 1'b1;
            end while (dup);
            y[i] = 8'($urandom_range(255, 1));
        end
        for (int k = 0; k < NSYND; k++) begin
            s[k] = 8'h00;
            for (int i = 0; i < v; i++) s[k] = s[k] ^ gmul(y[i], gexp[(p[i] * k) % 255]);
            sv[8*k +: 8] = s[k];
        end
        for (int j = 0; j <= NSYND; j++) lm[j] = (j == 0) ? 8'h01 : 8'h00;
        for (int i = 0; i < v; i++)
            for (int j = NSYND; j > 0; j--) lm[j] = lm[j] ^ gmul(gexp[p[i]], lm[j-1]);
        e.kind = (v <= T) ? 1 : 2;
        e.lam  = '0;
        e.om   = '0;
        for (int j = 0; j <= T; j++) e.lam[8*j +: 8] = lm[j];
        for (int k = 0; k < T; k++) begin
            acc = 8'h00;
            for (int j = 0; j <= k; j++) acc = acc ^ gmul(lm[j], s[k-j]);
            e.om[8*k +: 8] = acc;
        end
        e.nerr = v;
        e.fail = 1'b0;
        e.c0   = 0;
        issue(sv, e);
        wait_idle();
    endtask

    initial begin
        logic [8:0] fv;
        int         d0;
        fv = 9'h001;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = fv[7:0];
            glog[fv[7:0]] = i;
            fv = fv << 1;
            if (fv[8]) fv = fv ^ 9'h11D;
        end
        glog[0] = 0;

        // start held while in reset must not launch a run
        start = 1'b1;
        synd  = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        start = 1'b0;
        synd  = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 64'd0);
        chk("reset_done_count", n_done, 64'd0);
        chk("reset_lambda", lam, 64'd0);
        chk("reset_omega", om, 64'd0);
        chk("reset_nerr", nerr, 64'd0);
        chk("reset_fail", fail, 64'd0);

        issue(32'h00000000, mk_exact(24'h000001, 16'h0000, 0));
        wait_idle();
        issue(32'h01010101, mk_exact(24'h000101, 16'h0001, 1));
        wait_idle();

        for (int n = 0; n < 150; n++) run_errors(int'($urandom_range(T, 1)));
        for (int n = 0; n < 40; n++) run_errors(3);

        // start re-pulsed with junk syndromes every busy cycle
        d0 = n_done;
        @(negedge clk);
        start = 1'b1;
        synd  = 32'h01010101;
        begin
            exp_t e;
            e = mk_exact(24'h000101, 16'h0001, 1);
            e.c0 = cyc + 1;
            sbq.push_back(e);
        end
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (!busy) break;
            start = 1'b1;
            synd  = $urandom;
        end
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("one_done_per_start", n_done - d0, 64'd1);

        // reset during the second ITER cycle aborts cleanly
        issue(32'h01010101, mk_exact(24'h000101, 16'h0001, 1));
        @(negedge clk);
        d0  = n_done;
        rst = 1'b1;
        #1;
        sbq.delete();
        chk("abort_busy", busy, 64'd0);
        chk("abort_lambda", lam, 64'd0);
        chk("abort_omega", om, 64'd0);
        chk("abort_nerr", nerr, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (NSYND + 4) @(negedge clk);
        chk("abort_no_done", n_done - d0, 64'd0);
        issue(32'h01010101, mk_exact(24'h000101, 16'h0001, 1));
        wait_idle();
        chk("after_abort_done", n_done - d0, 64'd1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
